// File: rtl/wait_state_mem_responder.sv
// Wait-state memory responder: word RAM plus IO page (LEDs, optional cycle counter)
// behind the processor bus. Optional feature macro: MEM_CYCLE_COUNTER_EN.
module wait_state_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 0,
    parameter int IO_BIT      = 22
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic [4:0]  leds,
    output logic        dbg_state_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    // Handshake: a request (mem_rstrb or any mem_wmask bit) is taken only on an
    // edge where the responder is IDLE; while busy, strobes are dropped, so the
    // initiator must hold off until mem_rbusy/mem_wbusy are low.
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_rd_q, pend_rd_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] pend_data_q, pend_data_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  leds_q, leds_d;

    logic [31:0] ram_q [DEPTH_WORDS];

    logic          is_wr, req, accept, is_io;
    logic [AW-1:0] idx;
    logic [1:0]    io_off;
    logic [31:0]   rd_val, cyc_val;
    logic          unused_addr;

    assign is_wr       = |mem_wmask;
    assign req         = mem_rstrb | is_wr;
    assign accept      = resetn & (state_q == IDLE) & req;
    assign is_io       = mem_addr[IO_BIT];
    assign idx         = mem_addr[2 +: AW];
    assign io_off      = mem_addr[3:2];
    assign unused_addr = ^mem_addr;

`ifdef MEM_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;

    always_ff @(posedge clk) begin
        if (!resetn) cyc_q <= '0;
        else         cyc_q <= cyc_q + 32'd1;
    end
    assign cyc_val = cyc_q;
`else
    assign cyc_val = '0;
`endif

    // Read value as seen at the acceptance edge, i.e. before any same-edge write.
    always_comb begin
        rd_val = '0;
        if (is_io) begin
            case (io_off)
                2'd0:    rd_val = {27'b0, leds_q};
                2'd1:    rd_val = cyc_val;
                default: rd_val = '0;
            endcase
        end else begin
            rd_val = ram_q[idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_rd_d   = pend_rd_q;
        pend_wr_d   = pend_wr_q;
        pend_data_d = pend_data_q;
        rdata_d     = rdata_q;
        leds_d      = leds_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        if (mem_rstrb) rdata_d = rd_val;
                    end else begin
                        state_d     = BUSY;
                        cnt_d       = LAT;
                        pend_rd_d   = mem_rstrb;
                        pend_wr_d   = is_wr;
                        pend_data_d = rd_val;
                    end
                    if (is_io && io_off == 2'd0 && mem_wmask[0]) leds_d = mem_wdata[4:0];
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pend_rd_d = 1'b0;
                    pend_wr_d = 1'b0;
                    if (pend_rd_q) rdata_d = pend_data_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_rd_q   <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_data_q <= '0;
            rdata_q     <= '0;
            leds_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_rd_q   <= pend_rd_d;
            pend_wr_q   <= pend_wr_d;
            pend_data_q <= pend_data_d;
            rdata_q     <= rdata_d;
            leds_q      <= leds_d;
        end
    end

    // RAM is deliberately outside the reset domain so contents survive resetn.
    always_ff @(posedge clk) begin
        if (accept && is_wr && !is_io) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i]) ram_q[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    assign mem_rdata   = rdata_q;
    assign mem_rbusy   = (state_q == BUSY) & pend_rd_q;
    assign mem_wbusy   = (state_q == BUSY) & pend_wr_q;
    assign leds        = leds_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_wait_state_mem_responder.sv
// Bench for wait_state_mem_responder: a zero-latency and a three-wait-state instance
// share one request bus and are checked against an array/arithmetic reference model.
module tb_wait_state_mem_responder;
    localparam int LAT_B  = 3;
    localparam int IO_BIT = 22;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;

    logic [31:0] rdata0, rdata3;
    logic        rbusy0, wbusy0, rbusy3, wbusy3, st0, st3;
    logic [4:0]  leds0, leds3;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [256];
    logic [4:0]  m_leds = '0;
    logic [31:0] cyc_m = '0;
    logic [31:0] exp_rd0 = '0;
    logic [31:0] exp_rd3 = '0;

    wait_state_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .IO_BIT(IO_BIT)) u_dut0 (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(rdata0),
        .mem_rbusy(rbusy0), .mem_wbusy(wbusy0), .leds(leds0), .dbg_state_o(st0)
    );

    wait_state_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_B), .IO_BIT(IO_BIT)) u_dut3 (
        .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(rdata3),
        .mem_rbusy(rbusy3), .mem_wbusy(wbusy3), .leds(leds3), .dbg_state_o(st3)
    );

    always #5 clk = ~clk;

    // Free-running cycle count as the responder should see it.
    always @(posedge clk) begin
        if (!resetn) cyc_m <= '0;
        else         cyc_m <= cyc_m + 32'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[IO_BIT]) begin
            if (((a >> 2) % 4) == 0) return {27'b0, m_leds};
`ifdef MEM_CYCLE_COUNTER_EN
            if (((a >> 2) % 4) == 1) return cyc_m;
`endif
            return 32'h0;
        end
        return m_mem[(a >> 2) % 256];
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] w;
        if (a[IO_BIT]) begin
            if (((a >> 2) % 4) == 0 && m[0]) m_leds = d[4:0];
        end else begin
            w = m_mem[(a >> 2) % 256];
            for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
            m_mem[(a >> 2) % 256] = w;
        end
    endtask

    // One request, then checks of both instances until the slow one is idle again.
    task automatic xact(input logic [31:0] a, input logic r, input logic [3:0] m, input logic [31:0] d);
        logic [31:0] exp;
        logic        w;
        w = (m != 4'h0);
        @(posedge clk); #1;
        mem_addr = a; mem_rstrb = r; mem_wmask = m; mem_wdata = d;
        exp = m_read(a);
        m_write(a, m, d);
        @(posedge clk); #1;
        mem_rstrb = 1'b0; mem_wmask = 4'h0; mem_addr = $urandom; mem_wdata = $urandom;
        if (r) exp_rd0 = exp;
        @(negedge clk);
        check("rdata_lat0", rdata0, exp_rd0);
        check("rbusy_lat0", {31'b0, rbusy0}, 32'h0);
        check("wbusy_lat0", {31'b0, wbusy0}, 32'h0);
        check("leds_lat0", {27'b0, leds0}, {27'b0, m_leds});
        for (int c = 1; c <= LAT_B; c++) begin
            if (c > 1) @(negedge clk);
            check("rbusy_wait", {31'b0, rbusy3}, {31'b0, r});
            check("wbusy_wait", {31'b0, wbusy3}, {31'b0, w});
            check("rdata_hold", rdata3, exp_rd3);
        end
        @(negedge clk);
        if (r) exp_rd3 = exp;
        check("rbusy_done", {31'b0, rbusy3}, 32'h0);
        check("wbusy_done", {31'b0, wbusy3}, 32'h0);
        check("rdata_done", rdata3, exp_rd3);
        check("leds_lat3", {27'b0, leds3}, {27'b0, m_leds});
    endtask

    initial begin
        logic [31:0] a, c1, c2;
        logic        r;
        logic [3:0]  m;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata3", rdata3, 32'h0);
        check("rst_busy", {30'b0, rbusy3, wbusy3}, 32'h0);
        check("rst_leds", {27'b0, leds0}, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Give every RAM word a defined value
        for (int i = 0; i < 256; i++) xact(i * 4, 1'b0, 4'hF, $urandom);

        // Zero latency write then read
        xact(32'h10, 1'b0, 4'hF, 32'hDEADBEEF);
        xact(32'h10, 1'b1, 4'h0, 32'h0);
        check("t1_read", rdata0, 32'hDEADBEEF);

        // Byte-lane merges
        xact(32'h20, 1'b0, 4'hF, 32'h0);
        xact(32'h20, 1'b0, 4'b0001, 32'h000000AA);
        xact(32'h20, 1'b0, 4'b0010, 32'h0000BB00);
        xact(32'h20, 1'b1, 4'h0, 32'h0);
        check("t2_merge", rdata0, 32'h0000BBAA);

        // Simultaneous read and write returns pre-write data
        xact(32'h20, 1'b1, 4'hF, 32'h11112222);
        check("rbw_old", rdata3, 32'h0000BBAA);
        xact(32'h20, 1'b1, 4'h0, 32'h0);
        check("rbw_new", rdata3, 32'h11112222);

        // Strobe during the wait period is ignored by the slow instance
        @(posedge clk); #1;
        mem_addr = 32'h10; mem_rstrb = 1'b1;
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        @(negedge clk);
        check("ign_busy1", {31'b0, rbusy3}, 32'h1);
        check("ign_lat0a", rdata0, 32'hDEADBEEF);
        @(posedge clk); #1;
        mem_addr = 32'h20; mem_rstrb = 1'b1;
        @(negedge clk);
        check("ign_busy2", {31'b0, rbusy3}, 32'h1);
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        @(negedge clk);
        check("ign_busy3", {31'b0, rbusy3}, 32'h1);
        check("ign_lat0b", rdata0, 32'h11112222);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ign_idle", {31'b0, rbusy3}, 32'h0);
            check("ign_rdata", rdata3, 32'hDEADBEEF);
        end
        exp_rd0 = 32'h11112222;
        exp_rd3 = 32'hDEADBEEF;

        // IO page: LED register
        xact(32'h1 << IO_BIT, 1'b0, 4'hF, 32'h0000001F);
        check("t4_leds", {27'b0, leds0}, 32'h1F);
        xact(32'h1 << IO_BIT, 1'b1, 4'h0, 32'h0);
        check("t4_ioread", rdata3, 32'h1F);
        xact((32'h1 << IO_BIT) | 32'hC, 1'b1, 4'hF, 32'hFFFFFFFF);
        check("io_off3", rdata3, 32'h0);

        // Address wrap
        xact(32'h400, 1'b0, 4'hF, 32'h12345678);
        xact(32'h0, 1'b1, 4'h0, 32'h0);
        check("t6_wrap", rdata0, 32'h12345678);

        // Cycle counter spacing
        xact((32'h1 << IO_BIT) | 32'h4, 1'b1, 4'h0, 32'h0);
        c1 = rdata0;
        repeat (5) @(posedge clk);
        xact((32'h1 << IO_BIT) | 32'h4, 1'b1, 4'h0, 32'h0);
        c2 = rdata0;
`ifdef MEM_CYCLE_COUNTER_EN
        check("t7_cyc_diff", c2 - c1, 32'd10);
`else
        check("t7_cyc_zero", c1 | c2, 32'h0);
`endif

        // Randomised traffic
        for (int i = 0; i < 200; i++) begin
            a = $urandom & ~(32'h1 << IO_BIT);
            if ($urandom_range(0, 7) == 0)
                a = (32'h1 << IO_BIT) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            r = 1'($urandom_range(0, 1));
            m = 4'($urandom_range(0, 15));
            if (!r && m == 4'h0) r = 1'b1;
            xact(a, r, m, $urandom);
        end

        // Reset with a read in flight
        xact(32'h1 << IO_BIT, 1'b0, 4'h1, 32'h00000015);
        xact(32'h40, 1'b0, 4'hF, 32'hCAFEF00D);
        @(posedge clk); #1;
        mem_addr = 32'h40; mem_rstrb = 1'b1;
        @(posedge clk); #1;
        mem_rstrb = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        m_leds = '0;
        exp_rd0 = '0;
        exp_rd3 = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t5_rdata3", rdata3, 32'h0);
            check("t5_rdata0", rdata0, 32'h0);
            check("t5_busy", {30'b0, rbusy3, wbusy3}, 32'h0);
            check("t5_leds", {27'b0, leds3}, 32'h0);
        end
        xact(32'h40, 1'b1, 4'h0, 32'h0);
        check("t5_ram_kept", rdata3, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
